// File: rtl/player_pkg.sv
// Shared player types and default game constants, used by the hit detector,
// player movement logic and score display.
package player_pkg;

    typedef enum logic [1:0] {
        HIT_ARMED,
        HIT_GRACE,
        HIT_OVER
    } hit_state_t;

    localparam int unsigned PLAYER_NUM_OBJ      = 4;
    localparam int unsigned PLAYER_LIVES        = 3;
    localparam int unsigned PLAYER_GRACE_FRAMES = 30;

endpackage

// File: rtl/frame_overlap_accum.sv
// Accumulates player/obstacle pixel overlaps over one frame; the registered result
// describes the frame just closed when startOfFrame arrives.
module frame_overlap_accum
    import player_pkg::*;
#(
    parameter int unsigned NUM_OBJ = PLAYER_NUM_OBJ
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               draw_player,
    input  logic [NUM_OBJ-1:0] draw_obj,
    input  logic [NUM_OBJ-1:0] obj_enable,
    output logic               hit_seen,
    output logic [NUM_OBJ-1:0] hit_mask
);

    logic [NUM_OBJ-1:0] overlap;
    logic               hit_seen_q;
    logic [NUM_OBJ-1:0] hit_mask_q;

    assign overlap = draw_obj & obj_enable & {NUM_OBJ{draw_player}};

    // The pixel on the startOfFrame cycle already belongs to the new frame.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hit_seen_q <= 1'b0;
            hit_mask_q <= '0;
        end else if (startOfFrame) begin
            hit_seen_q <= |overlap;
            hit_mask_q <= overlap;
        end else if (|overlap) begin
            hit_seen_q <= 1'b1;
            hit_mask_q <= hit_mask_q | overlap;
        end
    end

    assign hit_seen = hit_seen_q;
    assign hit_mask = hit_mask_q;

endmodule

// File: rtl/player_hit_detector.sv
// Frame-based player collision detector: counts hits, tracks lives, runs a
// post-hit grace window and a sticky game-over.
module player_hit_detector
    import player_pkg::*;
#(
    parameter int unsigned NUM_OBJ      = PLAYER_NUM_OBJ,
    parameter int unsigned LIVES        = PLAYER_LIVES,
    parameter int unsigned GRACE_FRAMES = PLAYER_GRACE_FRAMES,
    localparam int unsigned IdW         = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    localparam int unsigned LivesW      = $clog2(LIVES + 1),
    localparam int unsigned GraceW      = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               draw_player,
    input  logic [NUM_OBJ-1:0] draw_obj,
    input  logic [NUM_OBJ-1:0] obj_enable,
    input  logic               god_mode,
    output logic               collision,
    output logic [IdW-1:0]     hit_obj_id,
    output logic [LivesW-1:0]  lives_left,
    output logic               invulnerable,
    output logic               game_over
);

    logic               hit_seen;
    logic [NUM_OBJ-1:0] hit_mask;
    logic [IdW-1:0]     lowest_id;

    hit_state_t         state_q, state_d;
    logic [LivesW-1:0]  lives_q, lives_d;
    logic [GraceW-1:0]  grace_q, grace_d;
    logic               collision_q, collision_d;
    logic [IdW-1:0]     hit_obj_id_q, hit_obj_id_d;
    logic               invul_q;
    logic               over_q;

    frame_overlap_accum #(
        .NUM_OBJ (NUM_OBJ)
    ) u_accum (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .draw_player  (draw_player),
        .draw_obj     (draw_obj),
        .obj_enable   (obj_enable),
        .hit_seen     (hit_seen),
        .hit_mask     (hit_mask)
    );

    // Lowest-index obstacle wins when several hit in the same frame.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_mask[i]) begin
                lowest_id = IdW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        grace_d      = grace_q;
        collision_d  = 1'b0;
        hit_obj_id_d = hit_obj_id_q;
        if (startOfFrame) begin
            case (state_q)
                HIT_ARMED: begin
                    if (hit_seen && !god_mode && (lives_q != '0)) begin
                        collision_d  = 1'b1;
                        hit_obj_id_d = lowest_id;
                        lives_d      = lives_q - LivesW'(1);
                        if (lives_q == LivesW'(1)) begin
                            state_d = HIT_OVER;
                        end else begin
                            state_d = HIT_GRACE;
                            grace_d = GraceW'(GRACE_FRAMES - 1);
                        end
                    end
                end
                HIT_GRACE: begin
                    if (grace_q == '0) begin
                        state_d = HIT_ARMED;
                    end else begin
                        grace_d = grace_q - GraceW'(1);
                    end
                end
                HIT_OVER: begin
                    state_d = HIT_OVER;
                end
                default: begin
                    state_d = HIT_ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= HIT_ARMED;
            lives_q      <= LivesW'(LIVES);
            grace_q      <= '0;
            collision_q  <= 1'b0;
            hit_obj_id_q <= '0;
            invul_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            grace_q      <= grace_d;
            collision_q  <= collision_d;
            hit_obj_id_q <= hit_obj_id_d;
            invul_q      <= (state_d == HIT_GRACE);
            over_q       <= (state_d == HIT_OVER);
        end
    end

    assign collision    = collision_q;
    assign hit_obj_id   = hit_obj_id_q;
    assign lives_left   = lives_q;
    assign invulnerable = invul_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_player_hit_detector.sv
// Scoreboard bench for player_hit_detector: frame-level reference model feeds
// expected status/pulse queues, a negedge monitor pops and compares.
module tb_player_hit_detector;

    localparam int unsigned NUM_OBJ = 4;
    localparam int unsigned LIVES   = 3;
    localparam int unsigned GRACE   = 30;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       draw_player = 1'b0;
    logic       god_mode = 1'b0;
    logic [3:0] draw_obj = 4'h0;
    logic [3:0] obj_enable = 4'h0;
    logic       collision;
    logic [1:0] hit_obj_id;
    logic [1:0] lives_left;
    logic       invulnerable;
    logic       game_over;

    always #5 clk = ~clk;

    player_hit_detector #(
        .NUM_OBJ      (NUM_OBJ),
        .LIVES        (LIVES),
        .GRACE_FRAMES (GRACE)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .draw_player  (draw_player),
        .draw_obj     (draw_obj),
        .obj_enable   (obj_enable),
        .god_mode     (god_mode),
        .collision    (collision),
        .hit_obj_id   (hit_obj_id),
        .lives_left   (lives_left),
        .invulnerable (invulnerable),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic       col;
        logic [1:0] id;
        logic [1:0] lives;
        logic       inv;
        logic       over;
    } exp_t;

    exp_t       stat_q[$];
    logic [1:0] pulse_q[$];
    int         checks = 0;
    int         failures = 0;

    // Reference model: frame-level game rules.
    int         m_lives;
    int         m_immune;      // upcoming frame boundaries that ignore hits
    bit         m_over;
    logic [3:0] m_frame;       // obstacles overlapped in the open frame
    logic [1:0] m_id;

    function automatic logic [1:0] first_obj(input logic [3:0] m);
        logic [1:0] r;
        bit         found;
        r     = 2'd0;
        found = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                r     = 2'(i);
                found = 1;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        exp_t       e;
        logic [3:0] ov;
        logic       col;
        ov  = draw_player ? (draw_obj & obj_enable) : 4'h0;
        col = 1'b0;
        if (!resetN) begin
            m_lives  = LIVES;
            m_immune = 0;
            m_over   = 0;
            m_frame  = 4'h0;
            m_id     = 2'd0;
        end else if (startOfFrame) begin
            if (!m_over) begin
                if (m_immune > 0) begin
                    m_immune--;
                end else if (m_frame != 4'h0 && !god_mode) begin
                    col = 1'b1;
                    m_id = first_obj(m_frame);
                    m_lives--;
                    if (m_lives == 0) m_over = 1;
                    else m_immune = GRACE;
                end
            end
            m_frame = ov;
        end else begin
            m_frame = m_frame | ov;
        end
        if (!resetN || startOfFrame) begin
            e.col   = col;
            e.id    = m_id;
            e.lives = 2'(m_lives);
            e.inv   = (!m_over && m_immune > 0);
            e.over  = m_over;
            stat_q.push_back(e);
            if (col) pulse_q.push_back(m_id);
        end
    endtask

    task automatic step(input logic rst_n, input logic sof, input logic dp,
                        input logic [3:0] dobj, input logic [3:0] en, input logic god);
        @(negedge clk);
        resetN       = rst_n;
        startOfFrame = sof;
        draw_player  = dp;
        draw_obj     = dobj;
        obj_enable   = en;
        god_mode     = god;
        model_step();
    endtask

    // One frame: SOF cycle without overlap, then an optional overlap on pixel 2.
    task automatic frame(input int len, input logic [3:0] obj, input logic [3:0] en,
                         input logic god_sof, input logic god_mid);
        logic [3:0] noise;
        noise = 4'($urandom);
        step(1'b1, 1'b1, 1'b0, noise, 4'hF, god_sof);
        for (int i = 1; i < len; i++) begin
            noise = 4'($urandom);
            step(1'b1, 1'b0, (i == 2) && (obj != 4'h0), (i == 2) ? obj : noise,
                 (i == 2) ? en : 4'hF, (i == 3) ? god_mid : god_sof);
        end
    endtask

    // Monitor
    logic       chk_pend = 1'b0;
    exp_t       mon_got;
    exp_t       mon_exp;
    logic [1:0] mon_pid;

    always @(posedge clk) chk_pend <= startOfFrame || !resetN;

    always @(negedge clk) begin
        if (collision === 1'b1) begin
            checks++;
            if (pulse_q.size() == 0) begin
                failures++;
                $display("FAIL stray_collision: collision=1 none expected t=%0t", $time);
            end else begin
                mon_pid = pulse_q.pop_front();
                if (hit_obj_id !== mon_pid) begin
                    failures++;
                    $display("FAIL pulse_id: got %0d expected %0d t=%0t",
                             hit_obj_id, mon_pid, $time);
                end
            end
        end
        if (chk_pend) begin
            checks++;
            mon_got.col   = collision;
            mon_got.id    = hit_obj_id;
            mon_got.lives = lives_left;
            mon_got.inv   = invulnerable;
            mon_got.over  = game_over;
            if (stat_q.size() == 0) begin
                failures++;
                $display("FAIL status_queue: no expected entry t=%0t", $time);
            end else begin
                mon_exp = stat_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL status: got col=%0b id=%0d lives=%0d inv=%0b over=%0b expected col=%0b id=%0d lives=%0d inv=%0b over=%0b t=%0t",
                             mon_got.col, mon_got.id, mon_got.lives, mon_got.inv, mon_got.over,
                             mon_exp.col, mon_exp.id, mon_exp.lives, mon_exp.inv, mon_exp.over,
                             $time);
                end
            end
        end
    end

    initial begin
        logic       hit_frame;
        logic [3:0] r_obj;
        int         len;

        // Reset, then quiet frames
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        for (int f = 0; f < 5; f++) frame(10, 4'h0, 4'hF, 1'b0, 1'b0);

        // Single-pixel hit on obstacle 2, then overlaps throughout grace
        frame(10, 4'b0100, 4'hF, 1'b0, 1'b0);
        for (int f = 0; f < GRACE + 1; f++) frame(10, 4'b0001, 4'hF, 1'b0, 1'b0);
        for (int f = 0; f < GRACE + 1; f++) frame(10, 4'h0, 4'hF, 1'b0, 1'b0);

        // God mode at SOF blocks; god mode only mid-frame does not
        frame(10, 4'b0010, 4'hF, 1'b0, 1'b0);
        frame(10, 4'h0, 4'hF, 1'b1, 1'b0);
        frame(10, 4'b0010, 4'hF, 1'b0, 1'b1);
        frame(10, 4'h0, 4'hF, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) frame(10, 4'b1000, 4'hF, 1'b0, 1'b0);

        // Reset out of game-over; masked obstacle 1 leaves obstacle 3 as the hit
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        frame(10, 4'b1010, 4'b1101, 1'b0, 1'b0);
        for (int f = 0; f < GRACE + 1; f++) frame(10, 4'h0, 4'hF, 1'b0, 1'b0);

        // Overlap only on the SOF pixel is counted at the following boundary
        step(1'b1, 1'b1, 1'b1, 4'b0001, 4'hF, 1'b0);
        for (int i = 1; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        frame(10, 4'h0, 4'hF, 1'b0, 1'b0);

        // Mid-frame reset discards the accumulated overlap
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0100, 4'hF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        frame(10, 4'h0, 4'hF, 1'b0, 1'b0);

        // Randomized play
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 19) == 0) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            len       = $urandom_range(6, 14);
            hit_frame = ($urandom_range(0, 2) == 0);
            step(1'b1, 1'b1, hit_frame && ($urandom_range(0, 3) == 0), 4'($urandom),
                 4'($urandom), ($urandom_range(0, 3) == 0));
            for (int i = 1; i < len; i++) begin
                r_obj = 4'($urandom);
                step(1'b1, 1'b0, hit_frame && ($urandom_range(0, 4) == 0), r_obj,
                     4'($urandom), 1'($urandom));
            end
        end
        frame(4, 4'h0, 4'hF, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stat_q.size() != 0 || pulse_q.size() != 0) begin
            failures++;
            $display("FAIL drain: status entries left %0d, pulses left %0d expected 0 and 0",
                     stat_q.size(), pulse_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
